// File: rtl/pc_stack_ctrl.sv
`timescale 1ns/1ps
// pc_stack_ctrl: call/return sequencer in front of the 16-entry PC/flag stack.
// Turns call/irq/ret/reti requests into push/pop strobes and PC/flag reload
// strobes, and tracks occupancy with sticky overflow/underflow flags.
// Optional: define PC_STACK_CTRL_WATERMARK_EN to add the max_depth output.
//
// Handshake: a requester raises exactly one of call_req/ret_req/irq_req/
// reti_req (or several, resolved irq > call > reti > ret) and holds it until
// it sees ack high for one cycle; it drops the request on the following edge.
// Requests are only looked at while the sequencer is idle (busy=0).
module pc_stack_ctrl #(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  FLAG_WIDTH  = 4,
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR  = 8'h01,
   parameter int                  STACK_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           call_req,
   input  logic                           ret_req,
   input  logic                           irq_req,
   input  logic                           reti_req,
   input  logic [PC_WIDTH-1:0]            target_addr,
   input  logic [PC_WIDTH-1:0]            pc_in,
   input  logic [FLAG_WIDTH-1:0]          flags_in,
   input  logic                           err_clr,
   output logic                           stk_push,
   output logic                           stk_pop,
   output logic [PC_WIDTH+FLAG_WIDTH-1:0] stk_din,
   input  logic [PC_WIDTH+FLAG_WIDTH-1:0] stk_dout,
   output logic                           pc_load,
   output logic [PC_WIDTH-1:0]            pc_out,
   output logic                           flags_load,
   output logic [FLAG_WIDTH-1:0]          flags_out,
   output logic                           ack,
   output logic                           busy,
   output logic [4:0]                     depth,
   output logic                           ovf_err,
   output logic                           unf_err,
`ifdef PC_STACK_CTRL_WATERMARK_EN
   output logic [4:0]                     max_depth,
`endif
   output logic [1:0]                     dbg_state
);

   localparam int         DW   = PC_WIDTH + FLAG_WIDTH;
   localparam logic [4:0] FULL = 5'(STACK_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_RESTORE} state_t;
   typedef enum logic [1:0] {OP_CALL, OP_RET, OP_IRQ, OP_RETI} op_t;

   state_t                state, state_next;
   op_t                   op_q, op_next;
   logic [DW-1:0]         data_q;       // push payload, later the popped entry
   logic [PC_WIDTH-1:0]   target_q;
   logic [4:0]            depth_q, depth_next;
   logic                  ovf_q, unf_q;
   logic                  accept, latch_pop, ovf_set, unf_set;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state, strobes and occupancy update.
   always_comb begin
      state_next = state;
      op_next    = op_q;
      depth_next = depth_q;
      accept     = 1'b0;
      latch_pop  = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      pc_load    = 1'b0;
      pc_out     = '0;
      flags_load = 1'b0;
      flags_out  = '0;
      ack        = 1'b0;
      case (state)
         S_IDLE: begin
            if (irq_req) begin
               op_next = OP_IRQ;  state_next = S_PUSH; accept = 1'b1;
            end else if (call_req) begin
               op_next = OP_CALL; state_next = S_PUSH; accept = 1'b1;
            end else if (reti_req) begin
               op_next = OP_RETI; state_next = S_POP;  accept = 1'b1;
            end else if (ret_req) begin
               op_next = OP_RET;  state_next = S_POP;  accept = 1'b1;
            end
         end
         S_PUSH: begin
            ack        = 1'b1;
            state_next = S_IDLE;
            if (depth_q != FULL) begin
               stk_push   = 1'b1;
               pc_load    = 1'b1;
               pc_out     = (op_q == OP_IRQ) ? IRQ_VECTOR : target_q;
               depth_next = depth_q + 5'd1;
            end else begin
               // Full stack: refuse the push so the stack pointer cannot wrap.
               ovf_set = 1'b1;
            end
         end
         S_POP: begin
            if (depth_q != 5'd0) begin
               stk_pop    = 1'b1;
               latch_pop  = 1'b1;
               depth_next = depth_q - 5'd1;
               state_next = S_RESTORE;
            end else begin
               unf_set    = 1'b1;
               ack        = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_RESTORE: begin
            ack        = 1'b1;
            pc_load    = 1'b1;
            pc_out     = data_q[PC_WIDTH-1:0];
            state_next = S_IDLE;
            if (op_q == OP_RETI) begin
               flags_load = 1'b1;
               flags_out  = data_q[DW-1:PC_WIDTH];
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operation registers, occupancy counter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_CALL;
         data_q   <= '0;
         target_q <= '0;
         depth_q  <= 5'd0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q     <= op_next;
            data_q   <= {flags_in, pc_in};
            target_q <= target_addr;
         end else if (latch_pop) begin
            data_q <= stk_dout;
         end
         depth_q <= depth_next;
         // A new error in the same cycle as err_clr must still be recorded.
         if (ovf_set)      ovf_q <= 1'b1;
         else if (err_clr) ovf_q <= 1'b0;
         if (unf_set)      unf_q <= 1'b1;
         else if (err_clr) unf_q <= 1'b0;
      end
   end

`ifdef PC_STACK_CTRL_WATERMARK_EN
   logic [4:0] max_q;

   // High-water mark of depth, restarted from the current depth by err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  max_q <= 5'd0;
      else if (err_clr)            max_q <= depth_next;
      else if (depth_next > max_q) max_q <= depth_next;
   end

   assign max_depth = max_q;
`endif

   assign stk_din   = data_q;
   assign busy      = (state != S_IDLE);
   assign depth     = depth_q;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;
   assign dbg_state = state;

endmodule
